// File: rtl/npc_car_motion.sv
// npc_car_motion: position and visibility of one NPC car.
// The car spawns in a pseudo-random lane and scrolls vertically once per
// frame, relative to the player's speed. It is retired when it leaves the
// screen, and it flashes for a fixed number of frames after a crash.
module npc_car_motion #(
   parameter int          ROAD_LEFT    = 160,
   parameter int          LANE_W       = 64,
   parameter int          NUM_LANES    = 5,
   parameter int          SCREEN_H     = 480,
   parameter int          NPC_SPEED    = 2,
   parameter int          SPAWN_DELAY  = 30,
   parameter int          FLASH_FRAMES = 32,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       VGA_VS,
   input  logic [7:0] keycode,
   input  logic       gamereset,
   input  logic [2:0] player_speed,
   input  logic       collide,
   output logic [9:0] CarX,
   output logic [9:0] CarY,
   output logic       npcclk,
   output logic       passed
);

   localparam int CNT_MAX = (SPAWN_DELAY > FLASH_FRAMES) ? SPAWN_DELAY : FLASH_FRAMES;
   localparam int CNT_W   = (CNT_MAX < 7) ? 3 : $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] SPAWN_CNT = CNT_W'(SPAWN_DELAY);
   localparam logic [CNT_W-1:0] FLASH_CNT = CNT_W'(FLASH_FRAMES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [3:0]       LANES     = 4'(NUM_LANES);
   localparam logic [9:0]       X_BASE    = 10'(ROAD_LEFT + (LANE_W - 40) / 2);
   localparam logic [9:0]       X_STEP    = 10'(LANE_W);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACTIVE,
      S_CRASH
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
   logic [15:0]       lfsr_q, lfsr_d;
   logic [9:0]        car_x_q, car_x_d;
   logic [9:0]        car_y_q, car_y_d;
   logic              vs_q, vs_d;
   logic              started_q, started_d;
   logic              passed_q, passed_d;

   logic              tick;
   logic [3:0]        lane;
   logic [9:0]        spawn_x;
   logic signed [10:0] dy;
   logic signed [10:0] ny;

   // A frame starts on the falling edge of the active-low vertical sync.
   assign tick = vs_q & ~VGA_VS;

   // Fold the 3-bit random value into the lane range, then place the car centred in its lane.
   always_comb begin
      lane = {1'b0, lfsr_q[2:0]};
      if (lane >= LANES) lane = lane - LANES;
      if (lane >= LANES) lane = 4'd0;
      spawn_x = X_BASE + 10'(lane) * X_STEP;
   end

   // Compute the vertical step relative to the player: negative values move the car up the screen.
   always_comb begin
      dy = $signed({8'd0, player_speed}) - $signed(11'(NPC_SPEED));
      ny = $signed({1'b0, car_y_q}) + dy;
   end

   // Next-state logic for the motion FSM.
   // The order of the checks gives gamereset priority over collide, and collide priority over tick.
   always_comb begin
      // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      car_x_d     = car_x_q;
      car_y_d     = car_y_q;
      passed_d    = 1'b0;
      vs_d        = VGA_VS;
      started_d   = started_q | (keycode == 8'h15);
      lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

      if (gamereset) begin
         if (started_q) begin
            state_d     = S_WAIT;
            frame_cnt_d = SPAWN_CNT;
            car_y_d     = 10'd0;
         end else begin
            state_d     = S_IDLE;
         end
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (started_q) begin
                  state_d     = S_WAIT;
                  frame_cnt_d = SPAWN_CNT;
               end
            end
            S_WAIT: begin
               if (tick) begin
                  if (frame_cnt_q == CNT_ONE) begin
                     state_d     = S_ACTIVE;
                     frame_cnt_d = '0;
                     car_x_d     = spawn_x;
                     car_y_d     = 10'd0;
                  end else begin
                     frame_cnt_d = frame_cnt_q - CNT_ONE;
                  end
               end
            end
            S_ACTIVE: begin
               if (collide) begin
                  state_d     = S_CRASH;
                  frame_cnt_d = FLASH_CNT;
               end else if (tick) begin
                  if (ny >= $signed(11'(SCREEN_H))) begin
                     passed_d    = 1'b1;
                     state_d     = S_WAIT;
                     frame_cnt_d = SPAWN_CNT;
                  end else if (ny[10]) begin
                     state_d     = S_WAIT;
                     frame_cnt_d = SPAWN_CNT;
                  end else begin
                     car_y_d     = ny[9:0];
                  end
               end
            end
            S_CRASH: begin
               if (tick) begin
                  if (frame_cnt_q == CNT_ONE) begin
                     state_d     = S_WAIT;
                     frame_cnt_d = SPAWN_CNT;
                  end else begin
                     frame_cnt_d = frame_cnt_q - CNT_ONE;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Register all state; the reset is asynchronous and returns the car to a hidden idle state.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q     <= S_IDLE;
         frame_cnt_q <= '0;
         lfsr_q      <= LFSR_SEED;
         car_x_q     <= 10'd0;
         car_y_q     <= 10'd0;
         vs_q        <= 1'b1;
         started_q   <= 1'b0;
         passed_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments, so that every flop samples the values from before the edge.
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         lfsr_q      <= lfsr_d;
         car_x_q     <= car_x_d;
         car_y_q     <= car_y_d;
         vs_q        <= vs_d;
         started_q   <= started_d;
         passed_q    <= passed_d;
      end
   end

   // The car is visible while ACTIVE. During CRASH it blinks, switching every 4 frames.
   assign npcclk = (state_q == S_ACTIVE) | ((state_q == S_CRASH) & ~frame_cnt_q[2]);
   assign CarX   = car_x_q;
   assign CarY   = car_y_q;
   assign passed = passed_q;

endmodule

// File: tb/tb_npc_car_motion.sv
// Directed bench for npc_car_motion: spawn, scrolling, both screen exits,
// crash flashing, gamereset priority and asynchronous reset.
module tb_npc_car_motion;

   logic       Clk;
   logic       Reset;
   logic       VGA_VS;
   logic [7:0] keycode;
   logic       gamereset;
   logic [2:0] player_speed;
   logic       collide;
   logic [9:0] CarX;
   logic [9:0] CarY;
   logic       npcclk;
   logic       passed;

   int n_checks = 0;
   int n_fail   = 0;

   npc_car_motion dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .VGA_VS       (VGA_VS),
      .keycode      (keycode),
      .gamereset    (gamereset),
      .player_speed (player_speed),
      .collide      (collide),
      .CarX         (CarX),
      .CarY         (CarY),
      .npcclk       (npcclk),
      .passed       (passed)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Count one comparison and report it if the observed value differs from the expected one.
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   // Produce one frame tick. Optional same-cycle collide/gamereset are asserted alongside it.
   // The task returns on a negedge, after the update has committed.
   task automatic frame_tick(input logic with_collide, input logic with_greset);
      @(negedge Clk);
      VGA_VS    = 1'b0;
      collide   = with_collide;
      gamereset = with_greset;
      @(negedge Clk);
      VGA_VS    = 1'b1;
      collide   = 1'b0;
      gamereset = 1'b0;
   endtask

   // Run n plain ticks and return how many of them showed a passed pulse.
   task automatic run_ticks(input int n, output int pass_seen);
      pass_seen = 0;
      for (int i = 0; i < n; i++) begin
         frame_tick(1'b0, 1'b0);
         if (passed) pass_seen++;
      end
   endtask

   // Start the game by pulsing the start key.
   task automatic press_start();
      @(negedge Clk);
      keycode = 8'h15;
      @(negedge Clk);
      keycode = 8'h00;
      repeat (2) @(negedge Clk);
   endtask

   function automatic logic valid_lane_x(input logic [9:0] x);
      return (x == 10'd172) || (x == 10'd236) || (x == 10'd300) ||
             (x == 10'd364) || (x == 10'd428);
   endfunction

   initial begin
      int         np;
      logic [9:0] x_spawn;

      Reset        = 1'b0;
      VGA_VS       = 1'b1;
      keycode      = 8'h00;
      gamereset    = 1'b0;
      player_speed = 3'd2;
      collide      = 1'b0;

      // Reset state.
      #12;
      check("rst_carx", 32'(CarX), 0);
      check("rst_cary", 32'(CarY), 0);
      check("rst_npcclk", 32'(npcclk), 0);
      check("rst_passed", 32'(passed), 0);
      @(negedge Clk);
      Reset = 1'b1;

      // Without the start key, the car never spawns.
      run_ticks(35, np);
      check("idle_no_spawn", 32'(npcclk), 0);

      // Spawn after exactly 30 ticks, in one of the five lane positions.
      press_start();
      run_ticks(29, np);
      check("wait_29_hidden", 32'(npcclk), 0);
      frame_tick(1'b0, 1'b0);
      check("spawn_visible", 32'(npcclk), 1);
      check("spawn_cary", 32'(CarY), 0);
      check("spawn_lane_x", 32'(valid_lane_x(CarX)), 1);
      x_spawn = CarX;

      // When player_speed equals the NPC speed, the car stays still.
      run_ticks(3, np);
      check("stationary_cary", 32'(CarY), 0);
      check("stationary_carx", 32'(CarX), 32'(x_spawn));

      // At speed 7 the car moves +5 per frame and exits the bottom on tick 96.
      player_speed = 3'd7;
      run_ticks(95, np);
      check("down_95_cary", 32'(CarY), 475);
      check("down_no_early_pass", 32'(np), 0);
      frame_tick(1'b0, 1'b0);
      check("bottom_passed", 32'(passed), 1);
      check("bottom_hidden", 32'(npcclk), 0);
      @(negedge Clk);
      check("passed_one_cycle", 32'(passed), 0);

      // Respawn, climb to CarY=3 at speed 3, then exit the top at speed 0.
      player_speed = 3'd3;
      run_ticks(29, np);
      check("respawn_29_hidden", 32'(npcclk), 0);
      frame_tick(1'b0, 1'b0);
      check("respawn_visible", 32'(npcclk), 1);
      run_ticks(3, np);
      check("up1_cary", 32'(CarY), 3);
      player_speed = 3'd0;
      frame_tick(1'b0, 1'b0);
      check("minus2_cary", 32'(CarY), 1);
      check("minus2_visible", 32'(npcclk), 1);
      frame_tick(1'b0, 1'b0);
      check("top_exit_no_pass", 32'(passed), 0);
      check("top_exit_hidden", 32'(npcclk), 0);

      // Respawn, move to CarY=100, then collide in the same cycle as a tick.
      player_speed = 3'd7;
      run_ticks(30, np);
      check("spawn3_visible", 32'(npcclk), 1);
      run_ticks(20, np);
      check("pre_crash_cary", 32'(CarY), 100);
      x_spawn = CarX;
      frame_tick(1'b1, 1'b0);
      check("crash_no_move", 32'(CarY), 100);
      check("crash_flash_start", 32'(npcclk), 1);
      // After tick i of CRASH, the frame count is 32-i and the car is visible when bit 2 is 0.
      for (int i = 1; i <= 31; i++) begin
         frame_tick(1'b0, 1'b0);
         check($sformatf("crash_flash_%0d", i), 32'(npcclk), ((32 - i) & 4) == 0 ? 1 : 0);
         check($sformatf("crash_frozen_y_%0d", i), 32'(CarY), 100);
      end
      check("crash_frozen_x", 32'(CarX), 32'(x_spawn));
      frame_tick(1'b0, 1'b0);
      check("crash_end_hidden", 32'(npcclk), 0);
      check("crash_end_no_pass", 32'(passed), 0);

      // A collide pulse while in WAIT is ignored, so the spawn count is unchanged.
      @(negedge Clk);
      collide = 1'b1;
      @(negedge Clk);
      collide = 1'b0;
      run_ticks(29, np);
      check("wait_collide_hidden", 32'(npcclk), 0);
      frame_tick(1'b0, 1'b0);
      check("wait_collide_spawn", 32'(npcclk), 1);

      // gamereset, collide and tick in the same cycle: gamereset wins and restarts a 30-frame wait.
      run_ticks(4, np);
      check("pre_greset_cary", 32'(CarY), 20);
      frame_tick(1'b1, 1'b1);
      check("greset_cary", 32'(CarY), 0);
      check("greset_hidden", 32'(npcclk), 0);
      check("greset_no_pass", 32'(passed), 0);
      run_ticks(29, np);
      check("greset_29_hidden", 32'(npcclk), 0);
      frame_tick(1'b0, 1'b0);
      check("greset_30_spawn", 32'(npcclk), 1);
      check("greset_spawn_y", 32'(CarY), 0);

      // Reset mid-ACTIVE clears the outputs at once, without waiting for a clock edge.
      run_ticks(2, np);
      check("pre_reset_cary", 32'(CarY), 10);
      @(negedge Clk);
      Reset = 1'b0;
      #1;
      check("async_rst_carx", 32'(CarX), 0);
      check("async_rst_cary", 32'(CarY), 0);
      check("async_rst_npcclk", 32'(npcclk), 0);
      @(negedge Clk);
      Reset = 1'b1;
      run_ticks(35, np);
      check("post_rst_no_spawn", 32'(npcclk), 0);
      // gamereset before start keeps the block in IDLE.
      frame_tick(1'b0, 1'b1);
      run_ticks(35, np);
      check("greset_unstarted_idle", 32'(npcclk), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
